// File: rtl/mem_stage.sv
// mem_stage: MIPS32 memory-access stage between EX and WB.
// Issues loads and stores to a synchronous data SRAM in the cycle the
// instruction is accepted from EX. An occupancy FSM (EMPTY/FRESH/HOLD)
// captures SRAM read data while WB stalls. Load data is aligned and
// extended before it is presented to WB.
// Optional build macro: MEM_ALIGN_CHECK_EN enables misaligned-access
// detection (suppresses the SRAM access, sets wb_ade, clears wb_rf_we).
// Reset is synchronous and active-low.
//
// state | meaning
// EMPTY | no instruction held for WB
// FRESH | instruction held; SRAM read data is on data_sram_rdata now
// HOLD  | instruction held; SRAM read data latched in hold_q
module mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_in,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_sign,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_dest,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        wb_rf_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        wb_ade
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] alu_q;
  logic        mem_read_q;
  logic [1:0]  mem_size_q;
  logic        mem_sign_q;
  logic        rf_we_q;
  logic [4:0]  dest_q;
  logic        ade_q;
  logic [31:0] hold_q;

  logic        accept;
  logic        misalign;
  logic        mem_op;
  logic [3:0]  wen_d;
  logic [31:0] wdata_d;
  logic [31:0] raw;
  logic [31:0] shifted;
  logic [31:0] extracted;

  assign mem_allowin = (state_q == EMPTY) || wb_allowin;
  assign accept      = ex_valid_in && mem_allowin;
  assign mem_op      = ex_mem_read || ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  // Half needs addr[0]==0; word (size 2 or 3) needs addr[1:0]==0.
  assign misalign = mem_op &&
                    (((ex_mem_size == 2'd1) && ex_alu_result[0]) ||
                     (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Store byte-enable and lane replication from size and low address bits.
  always_comb begin
    wen_d   = 4'b0000;
    wdata_d = ex_store_data;
    case (ex_mem_size)
      2'd0: begin
        wen_d   = 4'b0001 << ex_alu_result[1:0];
        wdata_d = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        wen_d   = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{ex_store_data[15:0]}};
      end
      default: begin
        wen_d   = 4'b1111;
        wdata_d = ex_store_data;
      end
    endcase
    if (!ex_mem_write) wen_d = 4'b0000;
  end

  // The SRAM is only touched in the accept cycle and never while in reset.
  assign data_sram_en    = accept && mem_op && reset && !misalign;
  assign data_sram_wen   = data_sram_en ? wen_d : 4'b0000;
  assign data_sram_addr  = {ex_alu_result[31:2], 2'b00};
  assign data_sram_wdata = wdata_d;

  // Align and extend load data from the live SRAM bus or the held copy.
  always_comb begin
    raw       = (state_q == FRESH) ? data_sram_rdata : hold_q;
    shifted   = raw;
    extracted = raw;
    case (mem_size_q)
      2'd0: begin
        shifted   = raw >> {alu_q[1:0], 3'b000};
        extracted = {{24{mem_sign_q & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        shifted   = raw >> {alu_q[1], 4'b0000};
        extracted = {{16{mem_sign_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted   = raw;
        extracted = raw;
      end
    endcase
  end

  assign wb_valid = (state_q != EMPTY);
  assign wb_pc    = pc_q;
  assign wb_rf_we = rf_we_q;
  assign wb_dest  = dest_q;
  assign wb_ade   = ade_q;
  assign wb_data  = mem_read_q ? extracted : alu_q;

  // Occupancy FSM with the registered instruction payload and read-data hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      pc_q       <= RESET_PC;
      alu_q      <= 32'h0;
      mem_read_q <= 1'b0;
      mem_size_q <= 2'd0;
      mem_sign_q <= 1'b0;
      rf_we_q    <= 1'b0;
      dest_q     <= 5'd0;
      ade_q      <= 1'b0;
      hold_q     <= 32'h0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_q <= FRESH;
        end
        FRESH: begin
          if (!wb_allowin) begin
            state_q <= HOLD;
            hold_q  <= data_sram_rdata;
          end else if (accept) begin
            state_q <= FRESH;
          end else begin
            state_q <= EMPTY;
          end
        end
        HOLD: begin
          if (wb_allowin) state_q <= accept ? FRESH : EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        pc_q       <= ex_pc;
        alu_q      <= ex_alu_result;
        mem_read_q <= ex_mem_read;
        mem_size_q <= ex_mem_size;
        mem_sign_q <= ex_mem_sign;
        rf_we_q    <= ex_rf_we && !misalign;
        dest_q     <= ex_dest;
        ade_q      <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_in;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_sign;
  logic        ex_rf_we;
  logic [4:0]  ex_dest;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_ade;

  int n_chk = 0;
  int n_bad = 0;

  mem_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ex_valid_in(ex_valid_in), .mem_allowin(mem_allowin),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_sign(ex_mem_sign), .ex_rf_we(ex_rf_we), .ex_dest(ex_dest),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_ade(wb_ade)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid_in   = 1'b0;
    ex_pc         = 32'h0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_size   = 2'd0;
    ex_mem_sign   = 1'b0;
    ex_rf_we      = 1'b0;
    ex_dest       = 5'd0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic we, input logic [4:0] dst);
    ex_valid_in   = 1'b1;
    ex_pc         = pc;
    ex_alu_result = addr;
    ex_store_data = sd;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_mem_size   = sz;
    ex_mem_sign   = sg;
    ex_rf_we      = we;
    ex_dest       = dst;
  endtask

  initial begin
    idle();
    reset           = 1'b0;
    wb_allowin      = 1'b1;
    data_sram_rdata = 32'h0;

    // Reset: SRAM gated even with a valid store presented.
    #1;
    issue(32'h10, 32'h100, 32'h1234_5678, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd3);
    #1;
    chk("rst_en", {31'h0, data_sram_en}, 32'h0);
    chk("rst_wen", {28'h0, data_sram_wen}, 32'h0);
    step();
    step();
    chk("rst_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_pc", wb_pc, RPC);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_rfwe", {31'h0, wb_rf_we}, 32'h0);
    chk("rst_dest", {27'h0, wb_dest}, 32'h0);
    chk("rst_ade", {31'h0, wb_ade}, 32'h0);
    chk("rst_allowin", {31'h0, mem_allowin}, 32'h1);

    // Word store then word load.
    reset = 1'b1;
    issue(32'h1000, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0);
    #1;
    chk("sw_en", {31'h0, data_sram_en}, 32'h1);
    chk("sw_wen", {28'h0, data_sram_wen}, 32'hF);
    chk("sw_addr", data_sram_addr, 32'h100);
    chk("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    step();
    chk("sw_valid", {31'h0, wb_valid}, 32'h1);
    chk("sw_pc", wb_pc, 32'h1000);
    issue(32'h1004, 32'h100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5);
    #1;
    chk("lw_en", {31'h0, data_sram_en}, 32'h1);
    chk("lw_wen", {28'h0, data_sram_wen}, 32'h0);
    step();
    idle();
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_pc", wb_pc, 32'h1004);
    chk("lw_dest", {27'h0, wb_dest}, 32'd5);
    chk("lw_rfwe", {31'h0, wb_rf_we}, 32'h1);
    step();
    chk("drain_valid", {31'h0, wb_valid}, 32'h0);

    // Signed then unsigned byte load at 0x103, back to back.
    issue(32'h1100, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd6);
    step();
    data_sram_rdata = 32'h80FF_0000;
    issue(32'h1104, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd7);
    #1;
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    step();
    idle();
    #1;
    chk("lbu_data", wb_data, 32'h0000_0080);
    chk("lbu_pc", wb_pc, 32'h1104);

    // Signed half load at 0x102.
    issue(32'h1108, 32'h102, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd8);
    step();
    idle();
    data_sram_rdata = 32'h8001_1234;
    #1;
    chk("lh_data", wb_data, 32'hFFFF_8001);
    step();

    // Load stalled by WB for three cycles with changing SRAM data.
    issue(32'h2000, 32'h200, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9);
    wb_allowin = 1'b0;
    step();
    issue(32'h3000, 32'hCAFE_0000, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10);
    data_sram_rdata = 32'h1111_2222;
    #1;
    chk("st1_allowin", {31'h0, mem_allowin}, 32'h0);
    chk("st1_en", {31'h0, data_sram_en}, 32'h0);
    chk("st1_data", wb_data, 32'h1111_2222);
    step();
    data_sram_rdata = 32'h3333_4444;
    #1;
    chk("st2_allowin", {31'h0, mem_allowin}, 32'h0);
    chk("st2_data", wb_data, 32'h1111_2222);
    chk("st2_pc", wb_pc, 32'h2000);
    step();
    data_sram_rdata = 32'h5555_6666;
    #1;
    chk("st3_allowin", {31'h0, mem_allowin}, 32'h0);
    chk("st3_data", wb_data, 32'h1111_2222);
    wb_allowin = 1'b1;
    #1;
    chk("st_release", {31'h0, mem_allowin}, 32'h1);
    chk("st_rel_en", {31'h0, data_sram_en}, 32'h0);
    step();
    chk("alu_after_pc", wb_pc, 32'h3000);
    chk("alu_after_data", wb_data, 32'hCAFE_0000);

    // Back-to-back ALU ops at full throughput.
    for (int i = 0; i < 4; i++) begin
      issue(32'h4000 + 32'(4 * i), 32'hA0 + 32'(i), 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'(i + 1));
      #1;
      chk("b2b_allowin", {31'h0, mem_allowin}, 32'h1);
      chk("b2b_en", {31'h0, data_sram_en}, 32'h0);
      step();
      chk("b2b_valid", {31'h0, wb_valid}, 32'h1);
      chk("b2b_pc", wb_pc, 32'h4000 + 32'(4 * i));
      chk("b2b_data", wb_data, 32'hA0 + 32'(i));
    end
    idle();
    step();

    // Reset while holding a load.
    issue(32'h6000, 32'h300, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd11);
    wb_allowin = 1'b0;
    step();
    idle();
    data_sram_rdata = 32'h7777_8888;
    step();
    reset = 1'b0;
    step();
    issue(32'h6004, 32'h304, 32'h9, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd12);
    data_sram_rdata = 32'h9999_AAAA;
    #1;
    chk("hrst_valid", {31'h0, wb_valid}, 32'h0);
    chk("hrst_pc", wb_pc, RPC);
    chk("hrst_en", {31'h0, data_sram_en}, 32'h0);
    chk("hrst_data", wb_data, 32'h0);
    idle();
    reset = 1'b1;
    wb_allowin = 1'b1;
    step();

    // Byte store at 0x102 and half store at 0x101.
    issue(32'h5000, 32'h102, 32'h0000_00AB, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("sb_wen", {28'h0, data_sram_wen}, 32'h4);
    chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    step();
    issue(32'h5004, 32'h101, 32'h0000_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd13);
    #1;
    chk("sh_wdata", data_sram_wdata, 32'hABCD_ABCD);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sh_en", {31'h0, data_sram_en}, 32'h0);
    chk("sh_wen", {28'h0, data_sram_wen}, 32'h0);
`else
    chk("sh_en", {31'h0, data_sram_en}, 32'h1);
    chk("sh_wen", {28'h0, data_sram_wen}, 32'h3);
`endif
    step();
    idle();
    #1;
    chk("sh_valid", {31'h0, wb_valid}, 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
    chk("sh_ade", {31'h0, wb_ade}, 32'h1);
    chk("sh_rfwe", {31'h0, wb_rf_we}, 32'h0);
`else
    chk("sh_ade", {31'h0, wb_ade}, 32'h0);
    chk("sh_rfwe", {31'h0, wb_rf_we}, 32'h1);
`endif
    issue(32'h5008, 32'h102, 32'h0000_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("sh_hi_wen", {28'h0, data_sram_wen}, 32'hC);
    step();
    idle();
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS32 pipeline, between EX and WB. It accepts one instruction per cycle from EX with a valid/allowin handshake and issues the load or store to the synchronous data SRAM in the accept cycle. It aligns and extends load data, then presents the result to WB. A 3-state occupancy FSM holds SRAM read data while WB stalls, so back-pressure never loses a load.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, reset value of the wb_pc register.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ex_valid_in  in  1  EX presents a valid instruction.
- mem_allowin  out  1  stage accepts from EX this cycle.
- ex_pc  in  32  instruction PC.
- ex_alu_result  in  32  effective address or ALU result.
- ex_store_data  in  32  rt value for stores.
- ex_mem_read / ex_mem_write  in  1 each  load / store.
- ex_mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ex_mem_sign  in  1  sign-extend loads.
- ex_rf_we  in  1  writes the register file.
- ex_dest  in  5  destination register.
- data_sram_en  out  1  SRAM access strobe.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  word address, {addr[31:2], 2'b00}.
- data_sram_wdata  out  32  replicated store data.
- data_sram_rdata  in  32  read data, valid the cycle after en.
- wb_allowin  in  1  WB accepts this cycle.
- wb_valid  out  1  stage holds a valid instruction.
- wb_pc  out  32  PC of that instruction.
- wb_rf_we  out  1  register-file write enable.
- wb_dest  out  5  destination register.
- wb_data  out  32  load result or ALU result.
- wb_ade  out  1  address-error flag.

## Operation
- Accept condition: accept = ex_valid_in && mem_allowin. mem_allowin = (state == EMPTY) || wb_allowin.
- On accept, every ex_* field is registered. data_sram_en = accept && (mem_read || mem_write) && reset.
- Store byte: wen = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
- Store half: wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
- Store word: wen = 4'b1111; wdata = sd.
- Loads and non-memory ops drive wen = 4'b0000.
- FSM states: EMPTY, FRESH (the SRAM read data is on data_sram_rdata this cycle), HOLD (read data latched in hold_q).
- EMPTY: accept → FRESH; otherwise stay.
- FRESH: wb_allowin && accept → FRESH; wb_allowin && !accept → EMPTY; !wb_allowin → HOLD, with hold_q <= data_sram_rdata.
- HOLD: wb_allowin && accept → FRESH; wb_allowin && !accept → EMPTY; otherwise stay.
- Load data source: raw = (state == FRESH) ? data_sram_rdata : hold_q.
- Load extraction: shift raw right by 8*addr[1:0] for bytes and 16*addr[1] for halves. Zero- or sign-extend per mem_sign.
- wb_data = mem_read ? extracted : registered alu_result.
- wb_valid = (state != EMPTY). readygo is always 1.

## Timing
- Reset (reset low at a clk edge) sets: state EMPTY, wb_valid 0, wb_pc RESET_PC, wb_rf_we 0, wb_dest 0, wb_data 0, wb_ade 0, hold_q 0.
- While reset is low, data_sram_en = 0 and wen = 0, regardless of ex_valid_in.
- Latency is 1 cycle: an instruction accepted at edge N is presented with wb_valid = 1 after edge N.
- Reset during FRESH or HOLD discards the pending read data. The SRAM response that arrives in the next cycle is ignored.
- Simultaneous drain and accept (wb_allowin and ex_valid_in both high while full) sustains full throughput with no bubble.
- A store completes at its accept edge. A store held in HOLD never re-drives the SRAM.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is misaligned. For a misaligned access, data_sram_en = 0, wen = 0, the instruction still flows to WB, wb_ade = 1, and wb_rf_we = 0.
- MEM_ALIGN_CHECK_EN undefined: low address bits are ignored as described in Operation, and wb_ade is tied to 0.

## Test plan
- Word store then load, mem_size 2: store sd = 32'hDEADBEEF to 32'h100 → wen 4'b1111, addr 32'h100. A following load returns wb_data 32'hDEADBEEF one cycle after its accept.
- Signed byte load at 32'h103 with rdata 32'h80FF_0000 → wb_data 32'hFFFF_FF80. The same load unsigned → 32'h0000_0080.
- Load accepted while wb_allowin is held 0 for 3 cycles, with rdata changing after the first cycle → the state goes to HOLD, wb_data keeps the first-cycle value, and mem_allowin = 0 until wb_allowin = 1.
- Back-to-back ALU ops for 4 cycles with wb_allowin = 1 → mem_allowin stays 1, each wb_valid pulse carries the matching pc and ALU result, and data_sram_en = 0.
- Reset asserted while in HOLD → the next cycle shows wb_valid 0, wb_pc RESET_PC, and data_sram_en 0.
- With MEM_ALIGN_CHECK_EN defined, a half store to 32'h101 → wen 4'b0000, wb_ade 1, wb_rf_we 0. Without the macro, the same store → wen 4'b0011 and wb_ade 0.
